// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: write-side sequencer for the shared 32-bit CPU bus.
// Accepts a (source, destination) register-transfer request, drives the bus
// select toward the bus multiplexer for a settle interval, then pulses exactly
// one destination load enable while capturing the bus value.
//
// Request handshake: a request is accepted on a rising clock edge where
// req_valid and req_ready are both 1. req_ready is 1 only in IDLE. Requests
// presented while req_ready is 0 are ignored, not queued, so the requester
// must hold req_valid (and the request fields) until it sees the accept.
// req_src and req_dst are latched at the accept edge; later changes to them
// do not affect the transfer in flight.
//
// Code map (shared by source and destination):
//   0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR,
//   22 InPort, 23 C_sign_extended.
// All codes 0-23 are valid sources; only 0-17, 20 and 21 are loadable.
module bus_xfer_sequencer #(
    parameter int SEL_W   = 5,
    parameter int NUM_DST = 24,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_src,
    input  logic [SEL_W-1:0]   req_dst,
    output logic [SEL_W-1:0]   bus_select,
    input  logic [31:0]        bus_data,
    output logic [NUM_DST-1:0] load_en,
    output logic               done,
    output logic               err,
    output logic [31:0]        last_data,
    output logic [15:0]        xfer_count
);

    // Code points that bound the valid source / destination sets.
    localparam logic [SEL_W-1:0] CODE_LO  = SEL_W'(17);
    localparam logic [SEL_W-1:0] CODE_PC  = SEL_W'(20);
    localparam logic [SEL_W-1:0] CODE_MDR = SEL_W'(21);
    localparam logic [SEL_W-1:0] CODE_MAX = SEL_W'(NUM_DST - 1);

    // The settle counter is loaded with SETTLE-1 so DRIVE lasts SETTLE cycles.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] src_q;
    logic [SEL_W-1:0] dst_q;
    logic [3:0]       settle_cnt;
    logic [15:0]      count_q;
    logic             src_ok;
    logic             dst_ok;
    logic             accept;
    logic             req_ok;

    // Request legality: any mapped code may source the bus, but the
    // read-only latches (ZHI, ZLO, InPort, C_sign_extended) cannot be loaded.
    always_comb begin
        src_ok = (req_src <= CODE_MAX);
        dst_ok = (req_dst <= CODE_LO) || (req_dst == CODE_PC) || (req_dst == CODE_MDR);
        accept = (state == ST_IDLE) && req_valid;
        req_ok = src_ok && dst_ok;
    end

    // State register; clr abandons any transfer in flight immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> DRIVE (SETTLE cycles) -> LOAD -> DONE -> IDLE,
    // or IDLE -> ERR -> IDLE for a rejected request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = req_ok ? ST_DRIVE : ST_ERR;
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state; load_en is combinational so that an
    // asynchronous clr drops it without waiting for a clock edge.
    always_comb begin
        req_ready = (state == ST_IDLE);
        done      = (state == ST_DONE);
        err       = (state == ST_ERR);
        load_en   = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            load_en[i] = (state == ST_LOAD) && (dst_q == SEL_W'(i));
        end
    end

    // Request latch and bus select: bus_select changes only on an accepted
    // legal request and otherwise holds the last driven source.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            src_q      <= '0;
            dst_q      <= '0;
            bus_select <= '0;
        end else if (accept) begin
            src_q <= req_src;
            dst_q <= req_dst;
            if (req_ok) begin
                bus_select <= req_src;
            end
        end
    end

    // Settle counter: loaded on accept, counts down through DRIVE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            settle_cnt <= '0;
        end else if (accept) begin
            settle_cnt <= SETTLE_INIT;
        end else if ((state == ST_DRIVE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Capture the bus value at the end of the single LOAD cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_data <= '0;
        end else if (state == ST_LOAD) begin
            last_data <= bus_data;
        end
    end

    // Completed-transfer counter, bumped at the end of DONE; wraps naturally.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else if (state == ST_DONE) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign xfer_count = count_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Testbench for bus_xfer_sequencer: table of transfer requests applied in a
// loop, plus hand-written sequences for back-to-back, mid-transfer reset,
// counter wrap and a SETTLE=4 instance.
module tb_bus_xfer_sequencer;

    localparam int SEL_W   = 5;
    localparam int NUM_DST = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT with SETTLE=1 ----------------
    logic               req_valid;
    logic               req_ready;
    logic [SEL_W-1:0]   req_src;
    logic [SEL_W-1:0]   req_dst;
    logic [SEL_W-1:0]   bus_select;
    logic [31:0]        bus_data;
    logic [NUM_DST-1:0] load_en;
    logic               done;
    logic               err;
    logic [31:0]        last_data;
    logic [15:0]        xfer_count;

    // ---------------- DUT with SETTLE=4 ----------------
    logic               req_valid_4;
    logic               req_ready_4;
    logic [SEL_W-1:0]   req_src_4;
    logic [SEL_W-1:0]   req_dst_4;
    logic [SEL_W-1:0]   bus_select_4;
    logic [31:0]        bus_data_4;
    logic [NUM_DST-1:0] load_en_4;
    logic               done_4;
    logic               err_4;
    logic [31:0]        last_data_4;
    logic [15:0]        xfer_count_4;

    // Bus multiplexer model: each source code returns a distinct word.
    function automatic logic [31:0] data_of(input logic [SEL_W-1:0] sel);
        if (sel == 5'd3) return 32'hDEADBEEF;
        return 32'hC0DE0000 + ({27'b0, sel} * 32'h11);
    endfunction

    assign bus_data   = data_of(bus_select);
    assign bus_data_4 = data_of(bus_select_4);

    bus_xfer_sequencer #(.SEL_W(SEL_W), .NUM_DST(NUM_DST), .SETTLE(1)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .bus_select (bus_select),
        .bus_data   (bus_data),
        .load_en    (load_en),
        .done       (done),
        .err        (err),
        .last_data  (last_data),
        .xfer_count (xfer_count)
    );

    bus_xfer_sequencer #(.SEL_W(SEL_W), .NUM_DST(NUM_DST), .SETTLE(4)) dut4 (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid_4),
        .req_ready  (req_ready_4),
        .req_src    (req_src_4),
        .req_dst    (req_dst_4),
        .bus_select (bus_select_4),
        .bus_data   (bus_data_4),
        .load_en    (load_en_4),
        .done       (done_4),
        .err        (err_4),
        .last_data  (last_data_4),
        .xfer_count (xfer_count_4)
    );

    // ---------------- scoreboard state ----------------
    int               n_vec  = 0;
    int               n_miss = 0;
    logic [15:0]      exp_cnt;
    logic [SEL_W-1:0] prev_sel;

    typedef struct {
        logic [SEL_W-1:0]   src;
        logic [SEL_W-1:0]   dst;
        bit                 is_err;
        logic [NUM_DST-1:0] exp_load;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer on the SETTLE=1 instance, checked cycle by cycle.
    // Entered and left at a falling edge with the DUT idle.
    task automatic run_xfer(input logic [SEL_W-1:0] src, input logic [SEL_W-1:0] dst,
                            input bit is_err, input logic [NUM_DST-1:0] exp_load);
        @(negedge clk);
        check("ready_before_accept", 32'(req_ready), 32'd1);
        req_src   = src;
        req_dst   = dst;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_src   = src ^ 5'h1F;
        req_dst   = dst ^ 5'h0A;
        if (is_err) begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_load_en", 32'(load_en), 32'd0);
            check("err_ready", 32'(req_ready), 32'd0);
            check("err_bus_select", 32'(bus_select), 32'(prev_sel));
            @(negedge clk);
            check("err_ready_back", 32'(req_ready), 32'd1);
            check("err_cleared", 32'(err), 32'd0);
            check("err_count", 32'(xfer_count), 32'(exp_cnt));
            check("err_bus_select_idle", 32'(bus_select), 32'(prev_sel));
        end else begin
            check("drive_bus_select", 32'(bus_select), 32'(src));
            check("drive_load_en", 32'(load_en), 32'd0);
            check("drive_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("load_load_en", 32'(load_en), 32'(exp_load));
            check("load_bus_select", 32'(bus_select), 32'(src));
            check("load_no_done", 32'(done), 32'd0);
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd1);
            check("done_load_en", 32'(load_en), 32'd0);
            check("done_ready", 32'(req_ready), 32'd0);
            exp_cnt  = exp_cnt + 16'd1;
            prev_sel = src;
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'd1);
            check("idle_done_clear", 32'(done), 32'd0);
            check("last_data", last_data, data_of(src));
            check("xfer_count", 32'(xfer_count), 32'(exp_cnt));
            check("idle_bus_select_hold", 32'(bus_select), 32'(src));
        end
    endtask

    initial begin
        int lat;
        int stable;
        int load_cyc;
        logic [NUM_DST-1:0] load_val;

        vecs[0] = '{src: 5'd3,  dst: 5'd7,  is_err: 1'b0, exp_load: 24'h000080};
        vecs[1] = '{src: 5'd3,  dst: 5'd19, is_err: 1'b1, exp_load: 24'h000000};
        vecs[2] = '{src: 5'd3,  dst: 5'd22, is_err: 1'b1, exp_load: 24'h000000};
        vecs[3] = '{src: 5'd3,  dst: 5'd30, is_err: 1'b1, exp_load: 24'h000000};
        vecs[4] = '{src: 5'd24, dst: 5'd5,  is_err: 1'b1, exp_load: 24'h000000};
        vecs[5] = '{src: 5'd23, dst: 5'd0,  is_err: 1'b0, exp_load: 24'h000001};
        vecs[6] = '{src: 5'd5,  dst: 5'd5,  is_err: 1'b0, exp_load: 24'h000020};
        vecs[7] = '{src: 5'd16, dst: 5'd17, is_err: 1'b0, exp_load: 24'h020000};
        vecs[8] = '{src: 5'd0,  dst: 5'd21, is_err: 1'b0, exp_load: 24'h200000};
        vecs[9] = '{src: 5'd18, dst: 5'd15, is_err: 1'b0, exp_load: 24'h008000};

        req_valid   = 1'b0;
        req_src     = '0;
        req_dst     = '0;
        req_valid_4 = 1'b0;
        req_src_4   = '0;
        req_dst_4   = '0;
        exp_cnt     = 16'd0;
        prev_sel    = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_bus_select", 32'(bus_select), 32'd0);
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_last_data", last_data, 32'd0);
        check("rst_count", 32'(xfer_count), 32'd0);
        clr = 1'b0;

        // ---- table-driven transfers ----
        for (int i = 0; i < 10; i++) begin
            run_xfer(vecs[i].src, vecs[i].dst, vecs[i].is_err, vecs[i].exp_load);
        end

        // ---- back-to-back with req_valid held: MDR->PC then PC->HI ----
        @(negedge clk);
        req_src   = 5'd21;
        req_dst   = 5'd20;
        req_valid = 1'b1;
        @(negedge clk);
        check("b2b_drive1", 32'(bus_select), 32'd21);
        req_src = 5'd20;
        req_dst = 5'd16;
        @(negedge clk);
        check("b2b_load1", 32'(load_en), 32'h100000);
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_not_ready_in_done", 32'(req_ready), 32'd0);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        check("b2b_hold_select", 32'(bus_select), 32'd21);
        check("b2b_last1", last_data, data_of(5'd21));
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_drive2", 32'(bus_select), 32'd20);
        @(negedge clk);
        check("b2b_load2", 32'(load_en), 32'h010000);
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("b2b_count", 32'(xfer_count), 32'(exp_cnt));
        check("b2b_last2", last_data, data_of(5'd20));

        // ---- asynchronous reset during LOAD ----
        @(negedge clk);
        req_src   = 5'd9;
        req_dst   = 5'd12;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_load_active", 32'(load_en), 32'h001000);
        #2;
        clr = 1'b1;
        #1;
        check("mid_load_en_drop", 32'(load_en), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_bus_select", 32'(bus_select), 32'd0);
        check("mid_last_data", last_data, 32'd0);
        check("mid_count", 32'(xfer_count), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 32'd0);
        end
        clr      = 1'b0;
        exp_cnt  = 16'd0;
        prev_sel = '0;

        // ---- counter wrap ----
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        check("wrap_preload", 32'(xfer_count), 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        run_xfer(5'd2, 5'd4, 1'b0, 24'h000010);

        // ---- SETTLE=4 instance: latency and bus_select stability ----
        lat      = 0;
        stable   = 0;
        load_cyc = 0;
        load_val = '0;
        @(negedge clk);
        req_src_4   = 5'd6;
        req_dst_4   = 5'd11;
        req_valid_4 = 1'b1;
        @(negedge clk);
        req_valid_4 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done_4) begin
                lat = c;
            end else begin
                if (bus_select_4 == 5'd6) stable++;
                if (load_en_4 != '0) begin
                    load_cyc = c;
                    load_val = load_en_4;
                end
            end
            if (lat != 0) break;
            @(negedge clk);
        end
        check("s4_latency", 32'(lat), 32'd6);
        check("s4_select_stable", 32'(stable), 32'd5);
        check("s4_load_cycle", 32'(load_cyc), 32'd5);
        check("s4_load_en", 32'(load_val), 32'h000800);
        @(negedge clk);
        check("s4_last_data", last_data_4, data_of(5'd6));
        check("s4_count", 32'(xfer_count_4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
